// File: rtl/duck_round_scheduler.sv
// Duck Hunt duck/round sequencer: spawns ducks, times their flight, tallies hits
// per round, advances rounds and flags game over.
module duck_round_scheduler #(
    parameter int unsigned CLK_PER_MS      = 65_000,
    parameter int unsigned FLY_TIME_MS     = 5000,
    parameter int unsigned DUCKS_PER_ROUND = 10,
    parameter int unsigned PASS_HITS       = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_enable,
    input  logic        hunt_start,
    input  logic        duck_killed,
    input  logic [6:0]  bullets_left,
    output logic        duck_spawn,
    output logic        duck_active,
    output logic        duck_escaped,
    output logic [11:0] spawn_xpos,
    output logic [3:0]  duck_index,
    output logic [3:0]  hits_in_round,
    output logic [3:0]  round_num,
    output logic [1:0]  speed_level,
    output logic        game_over
);

    localparam logic [31:0] FLY_LOAD = 32'(FLY_TIME_MS * CLK_PER_MS - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_HUNT, SPAWN, FLYING, RESOLVE, ROUND_END, GAME_OVER
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr;
    logic [31:0] fly_timer;
    logic        esc_flag, esc_nxt;
    logic [3:0]  idx_nxt, hits_nxt, round_nxt;

    // Fold the upper 96 columns back so a 96-px duck always fits in 1024 columns.
    function automatic logic [11:0] fold_xpos(input logic [9:0] r);
        return (r < 10'd928) ? {2'b00, r} : {2'b00, r - 10'd512};
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? 4'd15 : v + 4'd1;
    endfunction

    always_comb begin
        state_nxt = state;
        idx_nxt   = duck_index;
        hits_nxt  = hits_in_round;
        round_nxt = round_num;
        esc_nxt   = esc_flag;
        case (state)
            IDLE:      if (game_enable) state_nxt = WAIT_HUNT;
            WAIT_HUNT: if (hunt_start) state_nxt = SPAWN;
            SPAWN:     state_nxt = FLYING;
            FLYING: begin
                if (duck_killed) begin
                    hits_nxt  = hits_in_round + 4'd1;
                    esc_nxt   = 1'b0;
                    state_nxt = RESOLVE;
                end else if (fly_timer == '0 || bullets_left == 7'd0) begin
                    esc_nxt   = 1'b1;
                    state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                idx_nxt = duck_index + 4'd1;
                if (bullets_left == 7'd0)
                    state_nxt = GAME_OVER;
                else if (idx_nxt == 4'(DUCKS_PER_ROUND))
                    state_nxt = ROUND_END;
                else
                    state_nxt = WAIT_HUNT;
            end
            ROUND_END: begin
                if (32'(hits_in_round) >= PASS_HITS) begin
                    round_nxt = sat_inc(round_num);
                    idx_nxt   = 4'd0;
                    hits_nxt  = 4'd0;
                    state_nxt = WAIT_HUNT;
                end else begin
                    state_nxt = GAME_OVER;
                end
            end
            GAME_OVER: if (!game_enable) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        // Leaving the session aborts any duck in progress without an escape pulse.
        if (!game_enable && state != IDLE && state != GAME_OVER) begin
            state_nxt = IDLE;
            esc_nxt   = 1'b0;
        end
        if (state_nxt == IDLE) begin
            idx_nxt   = 4'd0;
            hits_nxt  = 4'd0;
            round_nxt = 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            lfsr          <= 16'hACE1;
            esc_flag      <= 1'b0;
            duck_index    <= 4'd0;
            hits_in_round <= 4'd0;
            round_num     <= 4'd1;
            spawn_xpos    <= 12'd0;
        end else begin
            state         <= state_nxt;
            lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            esc_flag      <= esc_nxt;
            duck_index    <= idx_nxt;
            hits_in_round <= hits_nxt;
            round_num     <= round_nxt;
            if (state_nxt == SPAWN && state != SPAWN)
                spawn_xpos <= fold_xpos(lfsr[9:0]);
        end
    end

    // Timer is only meaningful in FLYING and is always loaded in SPAWN first.
    always_ff @(posedge clk) begin
        if (state == SPAWN)
            fly_timer <= FLY_LOAD;
        else if (state == FLYING && fly_timer != '0)
            fly_timer <= fly_timer - 32'd1;
    end

    assign duck_spawn   = (state == SPAWN);
    assign duck_active  = (state == FLYING);
    assign duck_escaped = (state == RESOLVE) && esc_flag;
    assign game_over    = (state == GAME_OVER);
    assign speed_level  = (round_num > 4'd3) ? 2'd3 : 2'(round_num - 4'd1);

endmodule

// File: tb/tb_duck_round_scheduler.sv
// Bench for duck_round_scheduler: directed scenarios plus random play, checked
// every cycle against a phase-level model of the game rules.
module tb_duck_round_scheduler;

    localparam int FLY = 20, DUCKS = 3, PASS = 2;
    localparam int P_IDLE = 0, P_WAIT = 1, P_SPAWN = 2, P_FLY = 3, P_RES = 4, P_REND = 5, P_OVER = 6;

    logic        clk = 1'b0;
    logic        rst_n, game_enable, hunt_start, duck_killed;
    logic [6:0]  bullets_left;
    logic        duck_spawn, duck_active, duck_escaped, game_over;
    logic [11:0] spawn_xpos;
    logic [3:0]  duck_index, hits_in_round, round_num;
    logic [1:0]  speed_level;

    int checks = 0;
    int errors = 0;
    int n;

    int          m_ph, m_left, m_idx, m_hits, m_round, m_xpos;
    bit          m_kill;
    logic [15:0] m_lfsr;

    duck_round_scheduler #(
        .CLK_PER_MS(1), .FLY_TIME_MS(FLY), .DUCKS_PER_ROUND(DUCKS), .PASS_HITS(PASS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .game_enable(game_enable), .hunt_start(hunt_start),
        .duck_killed(duck_killed), .bullets_left(bullets_left), .duck_spawn(duck_spawn),
        .duck_active(duck_active), .duck_escaped(duck_escaped), .spawn_xpos(spawn_xpos),
        .duck_index(duck_index), .hits_in_round(hits_in_round), .round_num(round_num),
        .speed_level(speed_level), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int fold(input logic [15:0] l);
        int r;
        r = int'(l[9:0]);
        return (r >= 928) ? r - 512 : r;
    endfunction

    // One clock of the game rules, using the inputs seen at that edge.
    task automatic model_step();
        int np;
        if (!rst_n) begin
            m_ph = P_IDLE; m_left = 0; m_idx = 0; m_hits = 0; m_round = 1;
            m_xpos = 0; m_kill = 0; m_lfsr = 16'hACE1;
            return;
        end
        np = m_ph;
        if (!game_enable && m_ph != P_IDLE && m_ph != P_OVER) begin
            np = P_IDLE;
        end else begin
            case (m_ph)
                P_IDLE:  if (game_enable) np = P_WAIT;
                P_WAIT:  if (hunt_start) begin np = P_SPAWN; m_xpos = fold(m_lfsr); end
                P_SPAWN: begin np = P_FLY; m_left = FLY; end
                P_FLY: begin
                    if (duck_killed) begin m_hits++; m_kill = 1; np = P_RES; end
                    else if (m_left == 1 || bullets_left == 0) begin m_kill = 0; np = P_RES; end
                    else m_left--;
                end
                P_RES: begin
                    m_idx++;
                    if (bullets_left == 0) np = P_OVER;
                    else if (m_idx == DUCKS) np = P_REND;
                    else np = P_WAIT;
                end
                P_REND: begin
                    if (m_hits >= PASS) begin
                        m_round = (m_round < 15) ? m_round + 1 : 15;
                        m_idx = 0; m_hits = 0; np = P_WAIT;
                    end else np = P_OVER;
                end
                default: if (!game_enable) np = P_IDLE;
            endcase
        end
        if (np == P_IDLE) begin m_idx = 0; m_hits = 0; m_round = 1; end
        m_ph = np;
        m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("spawn",   duck_spawn,    m_ph == P_SPAWN);
            chk("active",  duck_active,   m_ph == P_FLY);
            chk("escaped", duck_escaped,  m_ph == P_RES && !m_kill);
            chk("over",    game_over,     m_ph == P_OVER);
            chk("xpos",    spawn_xpos,    m_xpos);
            chk("index",   duck_index,    m_idx);
            chk("hits",    hits_in_round, m_hits);
            chk("round",   round_num,     m_round);
            chk("speed",   speed_level,   (m_round - 1 > 3) ? 3 : m_round - 1);
        end
    end

    task automatic wait_spawn();
        int k = 0;
        while (!duck_spawn && k < 100) begin @(negedge clk); k++; end
        chk("spawn_seen", duck_spawn, 1);
    endtask

    initial begin
        rst_n = 1'b0; game_enable = 1'b0; hunt_start = 1'b0; duck_killed = 1'b0; bullets_left = 7'd50;
        repeat (3) @(negedge clk);
        chk("rst_round", round_num, 1);
        chk("rst_index", duck_index, 0);
        chk("rst_over", game_over, 0);
        chk("rst_xpos", spawn_xpos, 0);

        // Reset and first spawn
        rst_n = 1'b1; game_enable = 1'b1; hunt_start = 1'b1;
        @(negedge clk); chk("spawn_c2", duck_spawn, 0);
        @(negedge clk); chk("spawn_c3", duck_spawn, 1);
        chk("xpos_first", spawn_xpos, 451);
        chk("xpos_range", int'(spawn_xpos < 12'd928), 1);
        @(negedge clk);
        n = 0;
        while (duck_active && n < 40) begin n++; @(negedge clk); end
        chk("fly_len", n, 20);
        chk("esc_pulse", duck_escaped, 1);
        @(negedge clk);
        chk("idx_after_esc", duck_index, 1);
        chk("esc_single", duck_escaped, 0);

        // Kill on the timeout cycle counts as a kill
        wait_spawn();
        repeat (20) @(negedge clk);
        chk("last_fly", duck_active, 1);
        duck_killed = 1'b1;
        @(negedge clk);
        duck_killed = 1'b0; hunt_start = 1'b0;
        chk("kill_no_esc", duck_escaped, 0);
        chk("kill_hits", hits_in_round, 1);
        @(negedge clk);
        chk("idx_two", duck_index, 2);
        duck_killed = 1'b1;
        @(negedge clk);
        duck_killed = 1'b0;
        chk("wait_kill_ignored", hits_in_round, 1);
        repeat (2) @(negedge clk);
        chk("no_spawn_wo_hunt", duck_spawn, 0);
        hunt_start = 1'b1;

        // Round pass
        wait_spawn();
        repeat (5) @(negedge clk);
        duck_killed = 1'b1;
        @(negedge clk);
        duck_killed = 1'b0;
        repeat (2) @(negedge clk);
        chk("pass_round", round_num, 2);
        chk("pass_speed", speed_level, 1);
        chk("pass_idx", duck_index, 0);
        chk("pass_hits", hits_in_round, 0);
        wait_spawn();

        // Round fail: one kill out of three
        repeat (3) @(negedge clk);
        duck_killed = 1'b1;
        @(negedge clk);
        duck_killed = 1'b0;
        n = 0;
        while (!game_over && n < 200) begin n++; @(negedge clk); end
        chk("fail_over", game_over, 1);
        repeat (4) @(negedge clk);
        chk("fail_held", game_over, 1);
        chk("fail_round_frozen", round_num, 2);
        chk("fail_hits_frozen", hits_in_round, 1);
        game_enable = 1'b0;
        @(negedge clk);
        chk("drop_over", game_over, 0);
        chk("drop_round", round_num, 1);

        // Ammo out while flying
        game_enable = 1'b1;
        wait_spawn();
        repeat (4) @(negedge clk);
        bullets_left = 7'd0;
        @(negedge clk); chk("ammo_esc", duck_escaped, 1);
        @(negedge clk); chk("ammo_over", game_over, 1);
        game_enable = 1'b0; bullets_left = 7'd50;
        @(negedge clk);

        // Reset mid-flight
        game_enable = 1'b1;
        wait_spawn();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_active", duck_active, 0);
        chk("mid_rst_esc", duck_escaped, 0);
        chk("mid_rst_idx", duck_index, 0);
        chk("mid_rst_round", round_num, 1);
        chk("mid_rst_xpos", spawn_xpos, 0);
        rst_n = 1'b1;

        // Random play
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n        = ($urandom % 500) != 0;
            game_enable  = ($urandom % 40) != 0;
            hunt_start   = ($urandom % 4) != 0;
            duck_killed  = ($urandom % 8) == 0;
            bullets_left = (($urandom % 100) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
